// File: rtl/vector_writeback_stage.sv
// ---------------------------------------------------------------------------
// vector_writeback_stage
//
// Buffers execution-unit results in a small FIFO and presents them, one per
// cycle, to the vector register file write port. Each entry holds the
// destination register, the full result vector and a byte-enable mask that
// is derived at capture time from sew / vl / vm / v0_mask.
//
// Ports
//   clk               single clock, all state updates on its rising edge
//   reset             asynchronous, active-low reset
//   execution_result  result vector from the execution unit
//   execution_done    one-cycle pulse: execution_result and controls valid
//   vd_addr           destination vector register of the current result
//   sew               element width: 00=8b, 01=16b, 10=32b, 11=reserved
//   vl                active element count
//   vm                1 = unmasked, 0 = apply v0_mask
//   v0_mask           per-element mask, element i uses bit i
//   flush             synchronous buffer clear
//   wb_ready          VRF write port accepts a write this cycle
//   in_ready          buffer can accept a result
//   wb_valid          head entry presented to the VRF
//   wb_addr/data/be   head entry fields
//   overflow_err      sticky: a result was dropped because the buffer was full
//   sew_err           sticky: a reserved sew value was captured
//   wb_count          number of retired writes, saturating at 16'hFFFF
//
// The data width comes from the MAX_VLEN macro, normally supplied by
// vector_processor_defs.svh; a fallback keeps this file self-contained.
// ---------------------------------------------------------------------------
`ifndef MAX_VLEN
`define MAX_VLEN 128
`endif

module vector_writeback_stage #(
   parameter int DEPTH = 2   // legal values: 2 and 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [`MAX_VLEN-1:0]         execution_result,
   input  logic                         execution_done,
   input  logic [4:0]                   vd_addr,
   input  logic [1:0]                   sew,
   input  logic [$clog2(`MAX_VLEN/8):0] vl,
   input  logic                         vm,
   input  logic [`MAX_VLEN/8-1:0]       v0_mask,
   input  logic                         flush,
   input  logic                         wb_ready,
   output logic                         in_ready,
   output logic                         wb_valid,
   output logic [4:0]                   wb_addr,
   output logic [`MAX_VLEN-1:0]         wb_data,
   output logic [`MAX_VLEN/8-1:0]       wb_be,
   output logic                         overflow_err,
   output logic                         sew_err,
   output logic [15:0]                  wb_count
);

   localparam int NB  = `MAX_VLEN / 8;
   localparam int VLW = $clog2(NB) + 1;
   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH) + 1;

   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
   localparam logic [15:0]   COUNT_MAX = 16'hFFFF;

   // ------------------------------------------------------------------------
   // Byte-enable derivation. Walking bytes rather than elements means any
   // byte index maps to an element e < NB/W, so elements beyond the register
   // width are naturally ignored. The reserved sew value yields no enables.
   // ------------------------------------------------------------------------
   function automatic logic [NB-1:0] calc_be(
      input logic [1:0]     sew_i,
      input logic [VLW-1:0] vl_i,
      input logic           vm_i,
      input logic [NB-1:0]  mask_i
   );
      logic [NB-1:0]  be_v;
      logic [VLW-1:0] elem;
      be_v = '0;
      for (int b = 0; b < NB; b++) begin
         case (sew_i)
            2'b00:   elem = VLW'(b);
            2'b01:   elem = VLW'(b >> 1);
            2'b10:   elem = VLW'(b >> 2);
            default: elem = '0;
         endcase
         if ((sew_i != 2'b11) && (elem < vl_i) && (vm_i || mask_i[elem[VLW-2:0]])) begin
            be_v[b] = 1'b1;
         end else begin
            be_v[b] = 1'b0;
         end
      end
      return be_v;
   endfunction

   // Pointer increment with explicit wrap at DEPTH-1.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      if (p == LAST_PTR) begin
         return '0;
      end else begin
         return p + 1'b1;
      end
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [4:0]           ent_addr_q [DEPTH];
   logic [4:0]           ent_addr_d [DEPTH];
   logic [`MAX_VLEN-1:0] ent_data_q [DEPTH];
   logic [`MAX_VLEN-1:0] ent_data_d [DEPTH];
   logic [NB-1:0]        ent_be_q   [DEPTH];
   logic [NB-1:0]        ent_be_d   [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          overflow_err_q, overflow_err_d;
   logic          sew_err_q,      sew_err_d;
   logic [15:0]   wb_count_q,     wb_count_d;

   logic          full_s;
   logic          push_s;
   logic          pop_s;
   logic [NB-1:0] cap_be_s;

   // Handshake qualification; flush suppresses both push and pop.
   always_comb begin
      full_s   = (count_q == DEPTH_C);
      push_s   = execution_done && !full_s && !flush;
      pop_s    = (count_q != '0) && wb_ready && !flush;
      cap_be_s = calc_be(sew, vl, vm, v0_mask);
   end

   // Next-state computation for FIFO storage, pointers, count and status.
   always_comb begin
      ent_addr_d = ent_addr_q;
      ent_data_d = ent_data_q;
      ent_be_d   = ent_be_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      wb_count_d = wb_count_q;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_s) begin
            ent_addr_d[wr_ptr_q] = vd_addr;
            ent_data_d[wr_ptr_q] = execution_result;
            ent_be_d[wr_ptr_q]   = cap_be_s;
            wr_ptr_d             = next_ptr(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end

         if (pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
            if (wb_count_q != COUNT_MAX) begin
               wb_count_d = wb_count_q + 16'd1;
            end else begin
               wb_count_d = wb_count_q;
            end
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         // Simultaneous push and pop leaves occupancy unchanged.
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end

      // A pulse that meets a full buffer is dropped even if the head
      // retires this cycle: in_ready never looks at wb_ready.
      overflow_err_d = overflow_err_q | (execution_done && full_s);
      sew_err_d      = sew_err_q | (push_s && (sew == 2'b11));
   end

   // State registers, asynchronously cleared on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr_q[i] <= '0;
            ent_data_q[i] <= '0;
            ent_be_q[i]   <= '0;
         end
         rd_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         count_q        <= '0;
         overflow_err_q <= 1'b0;
         sew_err_q      <= 1'b0;
         wb_count_q     <= 16'd0;
      end else begin
         ent_addr_q     <= ent_addr_d;
         ent_data_q     <= ent_data_d;
         ent_be_q       <= ent_be_d;
         rd_ptr_q       <= rd_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         count_q        <= count_d;
         overflow_err_q <= overflow_err_d;
         sew_err_q      <= sew_err_d;
         wb_count_q     <= wb_count_d;
      end
   end

   // Outputs decode registered state only; no path from wb_ready or
   // execution_done, so a new entry is visible only after its capture edge.
   always_comb begin
      in_ready     = (count_q < DEPTH_C);
      wb_valid     = (count_q != '0);
      wb_addr      = ent_addr_q[rd_ptr_q];
      wb_data      = ent_data_q[rd_ptr_q];
      wb_be        = ent_be_q[rd_ptr_q];
      overflow_err = overflow_err_q;
      sew_err      = sew_err_q;
      wb_count     = wb_count_q;
   end

endmodule

// File: tb/tb_vector_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_vector_writeback_stage
//
// Self-checking bench: directed scenarios followed by randomized traffic,
// compared against a queue-based reference model of the writeback buffer.
// ---------------------------------------------------------------------------
`ifndef MAX_VLEN
`define MAX_VLEN 128
`endif

module tb_vector_writeback_stage;

   localparam int DEPTH = 2;
   localparam int NB    = `MAX_VLEN / 8;
   localparam int VLW   = $clog2(NB) + 1;

   typedef logic [`MAX_VLEN-1:0] word_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [`MAX_VLEN-1:0] execution_result;
   logic                 execution_done;
   logic [4:0]           vd_addr;
   logic [1:0]           sew;
   logic [VLW-1:0]       vl;
   logic                 vm;
   logic [NB-1:0]        v0_mask;
   logic                 flush;
   logic                 wb_ready;
   logic                 in_ready;
   logic                 wb_valid;
   logic [4:0]           wb_addr;
   logic [`MAX_VLEN-1:0] wb_data;
   logic [NB-1:0]        wb_be;
   logic                 overflow_err;
   logic                 sew_err;
   logic [15:0]          wb_count;

   vector_writeback_stage #(.DEPTH(DEPTH)) dut (
      .clk              (clk),
      .reset            (reset),
      .execution_result (execution_result),
      .execution_done   (execution_done),
      .vd_addr          (vd_addr),
      .sew              (sew),
      .vl               (vl),
      .vm               (vm),
      .v0_mask          (v0_mask),
      .flush            (flush),
      .wb_ready         (wb_ready),
      .in_ready         (in_ready),
      .wb_valid         (wb_valid),
      .wb_addr          (wb_addr),
      .wb_data          (wb_data),
      .wb_be            (wb_be),
      .overflow_err     (overflow_err),
      .sew_err          (sew_err),
      .wb_count         (wb_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]           addr;
      logic [`MAX_VLEN-1:0] data;
      logic [NB-1:0]        be;
   } entry_t;

   entry_t mq[$];
   int     m_ovf;
   int     m_sew;
   int     m_cnt;
   int     checks;
   int     errors;

   task automatic check_val(input string tag, input word_t obs, input word_t exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference byte enables, element by element.
   function automatic logic [NB-1:0] model_be(input logic [1:0] s, input int l,
                                              input logic m, input logic [NB-1:0] mk);
      logic [NB-1:0] r;
      int w;
      r = '0;
      if (s == 2'b11) return r;
      w = 1 << s;
      for (int e = 0; e < NB / w; e++) begin
         if (e < l && (m || mk[e])) begin
            for (int k = 0; k < w; k++) r[e*w + k] = 1'b1;
         end
      end
      return r;
   endfunction

   task automatic compare_outputs();
      check_val("in_ready", word_t'(in_ready), word_t'(mq.size() < DEPTH));
      check_val("wb_valid", word_t'(wb_valid), word_t'(mq.size() != 0));
      if (mq.size() != 0) begin
         check_val("wb_addr", word_t'(wb_addr), word_t'(mq[0].addr));
         check_val("wb_data", wb_data, mq[0].data);
         check_val("wb_be", word_t'(wb_be), word_t'(mq[0].be));
      end
      check_val("overflow_err", word_t'(overflow_err), word_t'(m_ovf));
      check_val("sew_err", word_t'(sew_err), word_t'(m_sew));
      check_val("wb_count", word_t'(wb_count), word_t'(m_cnt));
   endtask

   task automatic model_step();
      bit     full;
      bit     valid;
      entry_t e;
      full  = (mq.size() == DEPTH);
      valid = (mq.size() != 0);
      if (execution_done && full) m_ovf = 1;
      if (flush) begin
         mq.delete();
      end else begin
         if (valid && wb_ready) begin
            void'(mq.pop_front());
            if (m_cnt < 65535) m_cnt++;
         end
         if (execution_done && !full) begin
            e.addr = vd_addr;
            e.data = execution_result;
            e.be   = model_be(sew, int'(vl), vm, v0_mask);
            if (sew == 2'b11) m_sew = 1;
            mq.push_back(e);
         end
      end
   endtask

   // One clock: check at the falling edge, advance the model, return 1 after the rising edge.
   task automatic tick();
      @(negedge clk);
      compare_outputs();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_push(input logic [4:0] a, input word_t d, input logic [1:0] s,
                             input int l, input logic m, input logic [NB-1:0] mk);
      execution_done   = 1'b1;
      vd_addr          = a;
      execution_result = d;
      sew              = s;
      vl               = VLW'(l);
      vm               = m;
      v0_mask          = mk;
   endtask

   task automatic idle_in();
      execution_done = 1'b0;
      flush          = 1'b0;
   endtask

   initial begin
      int cnt_before;
      checks = 0; errors = 0; m_ovf = 0; m_sew = 0; m_cnt = 0;
      reset = 1'b0;
      execution_result = '0; execution_done = 1'b0; vd_addr = 5'd0; sew = 2'b00;
      vl = '0; vm = 1'b1; v0_mask = '0; flush = 1'b0; wb_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_wb_valid", word_t'(wb_valid), word_t'(1'b0));
      check_val("rst_in_ready", word_t'(in_ready), word_t'(1'b1));
      check_val("rst_wb_count", word_t'(wb_count), word_t'(16'd0));
      check_val("rst_wb_be", word_t'(wb_be), word_t'(0));
      #2 reset = 1'b1;

      // Basic capture, first push right after reset release
      drive_push(5'd3, word_t'(40'h0504030201), 2'b00, 5, 1'b1, '0);
      wb_ready = 1'b1;
      tick();
      idle_in();
      check_val("basic_valid", word_t'(wb_valid), word_t'(1'b1));
      check_val("basic_addr", word_t'(wb_addr), word_t'(5'd3));
      check_val("basic_be", word_t'(wb_be), word_t'(16'h001F));
      tick();
      check_val("basic_count", word_t'(wb_count), word_t'(16'd1));
      check_val("basic_empty", word_t'(wb_valid), word_t'(1'b0));

      // Masking
      wb_ready = 1'b0;
      drive_push(5'd4, word_t'(64'h1111), 2'b01, 4, 1'b0, NB'(16'b0101));
      tick();
      idle_in();
      check_val("mask_be16", word_t'(wb_be), word_t'(16'h0033));
      wb_ready = 1'b1;
      tick();
      drive_push(5'd5, word_t'(64'h2222), 2'b10, 2, 1'b1, '0);
      tick();
      idle_in();
      check_val("mask_be32", word_t'(wb_be), word_t'(16'h00FF));
      tick();

      // vl = 0 still retires
      drive_push(5'd6, word_t'(64'h3333), 2'b00, 0, 1'b1, '1);
      tick();
      idle_in();
      check_val("vl0_be", word_t'(wb_be), word_t'(0));
      check_val("vl0_valid", word_t'(wb_valid), word_t'(1'b1));
      tick();
      check_val("vl0_count", word_t'(wb_count), word_t'(16'd4));

      // Back-pressure and overflow
      wb_ready = 1'b0;
      drive_push(5'd10, word_t'(64'hA0), 2'b00, 16, 1'b1, '0);
      tick();
      check_val("bp_ready1", word_t'(in_ready), word_t'(1'b1));
      drive_push(5'd11, word_t'(64'hA1), 2'b00, 16, 1'b1, '0);
      tick();
      check_val("bp_ready2", word_t'(in_ready), word_t'(1'b0));
      drive_push(5'd12, word_t'(64'hA2), 2'b00, 16, 1'b1, '0);
      tick();
      idle_in();
      check_val("bp_ovf", word_t'(overflow_err), word_t'(1'b1));
      check_val("bp_head0", word_t'(wb_addr), word_t'(5'd10));
      wb_ready = 1'b1;
      tick();
      check_val("bp_head1", word_t'(wb_addr), word_t'(5'd11));
      tick();
      check_val("bp_drained", word_t'(wb_valid), word_t'(1'b0));
      check_val("bp_count", word_t'(wb_count), word_t'(16'd6));

      // Simultaneous push/pop across pointer wrap
      wb_ready = 1'b0;
      drive_push(5'd19, word_t'(64'h19), 2'b00, 1, 1'b1, '0);
      tick();
      wb_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_push(5'(20 + i), word_t'(64'h100 + i), 2'b00, 1, 1'b1, '0);
         tick();
         check_val("pp_valid", word_t'(wb_valid), word_t'(1'b1));
         check_val("pp_addr", word_t'(wb_addr), word_t'(20 + i));
      end
      idle_in();
      tick();

      // flush with two entries, then reserved sew
      wb_ready = 1'b0;
      drive_push(5'd1, word_t'(64'hF1), 2'b00, 3, 1'b1, '0);
      tick();
      drive_push(5'd2, word_t'(64'hF2), 2'b00, 3, 1'b1, '0);
      tick();
      idle_in();
      cnt_before = m_cnt;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check_val("flush_valid", word_t'(wb_valid), word_t'(1'b0));
      check_val("flush_count", word_t'(wb_count), word_t'(cnt_before));
      drive_push(5'd7, word_t'(64'h77), 2'b11, 4, 1'b1, '0);
      tick();
      idle_in();
      check_val("sew11_be", word_t'(wb_be), word_t'(0));
      check_val("sew11_err", word_t'(sew_err), word_t'(1'b1));

      // Async reset between edges while wb_valid = 1
      #3 reset = 1'b0;
      #1;
      check_val("arst_valid", word_t'(wb_valid), word_t'(1'b0));
      check_val("arst_in_ready", word_t'(in_ready), word_t'(1'b1));
      check_val("arst_count", word_t'(wb_count), word_t'(16'd0));
      check_val("arst_ovf", word_t'(overflow_err), word_t'(1'b0));
      check_val("arst_sew", word_t'(sew_err), word_t'(1'b0));
      check_val("arst_addr", word_t'(wb_addr), word_t'(0));
      check_val("arst_data", wb_data, word_t'(0));
      mq.delete();
      m_ovf = 0; m_sew = 0; m_cnt = 0;
      @(posedge clk);
      #1 reset = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         execution_done   = ($urandom_range(0, 1) == 1);
         flush            = ($urandom_range(0, 15) == 0);
         wb_ready         = ($urandom_range(0, 9) < 6);
         vd_addr          = 5'($urandom);
         execution_result = {$urandom, $urandom, $urandom, $urandom};
         sew              = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         vl               = VLW'($urandom_range(0, NB));
         vm               = 1'($urandom);
         v0_mask          = NB'($urandom);
         tick();
      end
      idle_in();
      wb_ready = 1'b1;
      repeat (DEPTH + 2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_writeback_stage.md
VECTOR_WRITEBACK_STAGE -- requirements
Module: vector_writeback_stage

Interface
REQ-001 Parameter DEPTH, default 2, sets the number of result entries buffered; legal values are 2 and 4.
REQ-002 Macro `MAX_VLEN` comes from vector_processor_defs.svh and sets the data width; NB = `MAX_VLEN`/8 bytes per result.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 execution_result  input  `MAX_VLEN`  result vector from the execution unit.
REQ-006 execution_done  input  1  one-cycle pulse marking execution_result valid.
REQ-007 vd_addr  input  5  destination vector register of the current result.
REQ-008 sew  input  2  element width: 00=8b, 01=16b, 10=32b, 11=reserved.
REQ-009 vl  input  $clog2(NB)+1  active element count.
REQ-010 vm  input  1  1 = unmasked; 0 = apply v0_mask.
REQ-011 v0_mask  input  NB  per-element mask bit, element i uses bit i.
REQ-012 flush  input  1  synchronous buffer clear.
REQ-013 wb_ready  input  1  the VRF write port accepts a write this cycle.
REQ-014 in_ready  output  1  the buffer can accept a result.
REQ-015 wb_valid  output  1  the head entry is presented to the VRF.
REQ-016 wb_addr  output  5  head entry destination register.
REQ-017 wb_data  output  `MAX_VLEN`  head entry data.
REQ-018 wb_be  output  NB  head entry byte enables.
REQ-019 overflow_err  output  1  sticky flag: a result was dropped.
REQ-020 sew_err  output  1  sticky flag: sew=11 was captured.
REQ-021 wb_count  output  16  number of retired writes, saturating.

Function
REQ-022 The FIFO has DEPTH entries of {vd_addr, data, be}, with rd_ptr, wr_ptr and an occupancy count of $clog2(DEPTH)+1 bits; both pointers wrap modulo DEPTH.
REQ-023 in_ready = (count < DEPTH), decoded from registered count only, with no combinational path from wb_ready.
REQ-024 Push: execution_done && in_ready writes the entry at wr_ptr; byte enables are computed combinationally at capture.
REQ-025 Byte enables, per element e:
- The element is enabled when e < vl && (vm || v0_mask[e]).
- An enabled element asserts bytes e*W .. e*W+W-1, where W = 1/2/4 bytes for sew 00/01/10.
- Elements with e >= NB/W are ignored.
REQ-026 sew=11: the entry is pushed with be all zero and sew_err is set.
REQ-027 vl=0: the entry is pushed with be all zero and still retires; it counts in wb_count.
REQ-028 Push latency: an entry captured on edge N makes wb_valid=1 after edge N, with no combinational bypass.
REQ-029 wb_valid = (count != 0); wb_addr, wb_data and wb_be come from the entry at rd_ptr.
REQ-030 Pop: wb_valid && wb_ready; rd_ptr advances and wb_count increments, saturating at 16'hFFFF.
REQ-031 Holding: while wb_valid && !wb_ready, the wb_* outputs hold stable.
REQ-032 Push and pop in the same cycle (count < DEPTH): both pointers advance and count is unchanged.
REQ-033 Full: execution_done while count == DEPTH drops the result, leaves state unchanged and sets overflow_err, even when a pop occurs that same cycle.
REQ-034 flush: on the next edge, count, rd_ptr and wr_ptr go to 0, and any push or pop in that cycle is ignored.
- overflow_err, sew_err and wb_count are not cleared by flush.
REQ-035 Sticky flags clear only on reset.

Reset
REQ-036 reset=0 immediately forces the following, regardless of clk:
- count=0, rd_ptr=0, wr_ptr=0
- wb_valid=0, in_ready=1
- wb_addr=0, wb_data=0, wb_be=0
- overflow_err=0, sew_err=0, wb_count=0
REQ-037 Reset asserted mid-transfer discards all buffered entries; no VRF write completes in that cycle.
REQ-038 The first push is accepted on the first rising edge after reset deasserts.

Verification
REQ-039 Basic capture: sew=00, vl=5, vm=1, data=0x..0504030201, vd=3, wb_ready=1 -> one cycle later wb_valid=1, wb_addr=3, wb_be=0x1F; retires on that edge; wb_count=1.
REQ-040 Masking: sew=01, vl=4, vm=0, v0_mask=...0101b -> wb_be=0x0033; sew=10, vl=2, vm=1 -> wb_be=0x00FF.
REQ-041 Back-pressure and overflow (DEPTH=2): wb_ready=0, three done pulses -> first two buffered, in_ready=0 after the second, third dropped, overflow_err=1; then wb_ready=1 -> two writes in push order, wb_count=2.
REQ-042 Simultaneous push/pop: count=1 with push and pop in the same cycle -> count stays 1, the new entry follows; run 10 consecutive cycles to exercise pointer wrap-around with no reordering.
REQ-043 flush with count=2 -> wb_valid=0 next cycle, wb_count unchanged; sew=11 push -> wb_be=0, sew_err=1.
REQ-044 Async reset asserted between clock edges while wb_valid=1 -> wb_valid=0 and in_ready=1 before the next edge, and all counters and flags read 0.
